// File: rtl/pxs_fronton_ctrl_if.sv
// pxs_fronton_ctrl_if: VGA stream, buttons and game-state outputs of the Fronton sequencer
interface pxs_fronton_ctrl_if;
  logic [22:0] VGAStr_i;
  logic        leftButton;
  logic        rightButton;
  logic        startButton;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [9:0]  paddle_x;
  logic [3:0]  speed;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic [2:0]  state;
  logic        frame_tick;
  modport master (
    output VGAStr_i, leftButton, rightButton, startButton,
    input  ball_x, ball_y, paddle_x, speed, score, lives, state, frame_tick
  );
  modport slave (
    input  VGAStr_i, leftButton, rightButton, startButton,
    output ball_x, ball_y, paddle_x, speed, score, lives, state, frame_tick
  );
endinterface

// File: rtl/pxs_fronton_ctrl.sv
// pxs_fronton_ctrl: Fronton game sequencer, advancing once per frame at the last visible pixel
module pxs_fronton_ctrl #(
  parameter int BALL_W         = 8,
  parameter int BALL_H         = 10,
  parameter int PADDLE_W       = 64,
  parameter int PADDLE_Y       = 440,
  parameter int SPEED_INIT     = 2,
  parameter int SPEED_MAX      = 8,
  parameter int HITS_PER_LEVEL = 4,
  parameter int LIVES_INIT     = 3,
  parameter int SERVE_FRAMES   = 60
) (
  input logic              px_clk,
  input logic              reset,
  pxs_fronton_ctrl_if.slave g
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4} state_e;
  localparam logic [9:0]  X0 = 10'd316, Y0 = 10'd100, P0 = 10'd288;
  localparam logic [9:0]  X_R = 10'(640 - BALL_W), Y_HIT = 10'(PADDLE_Y - BALL_H), Y_MISS = 10'(480 - BALL_H);
  localparam logic [9:0]  P_R = 10'(640 - PADDLE_W);
  localparam logic [10:0] XMAX = 11'(640 - BALL_W), YMAX = 11'(480 - BALL_H), PMAX = 11'(640 - PADDLE_W);
  localparam logic [10:0] PY = 11'(PADDLE_Y), BW = 11'(BALL_W), BH = 11'(BALL_H), PW = 11'(PADDLE_W);
  state_e      st_q, st_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d, px_q, px_d;
  logic [3:0]  spd_q, spd_d;
  logic [7:0]  sc_q, sc_d, hit_q, hit_d, srv_q, srv_d;
  logic [1:0]  lv_q, lv_d, l_q, r_q, s_q;
  logic        dx_q, dx_d, dy_q, dy_d, tick_q;
  logic        endframe, l, r, s, hit, lvl_up;
  logic [10:0] bx, by, px, sp, byh;
  // XC occupies bits [19:10] and YC bits [9:0] of the VGA stream
  assign endframe = g.VGAStr_i[19:10] == 10'd639 && g.VGAStr_i[9:0] == 10'd479;
  assign {l, r, s} = {l_q[1], r_q[1], s_q[1]};
  assign bx  = {1'b0, bx_q};
  assign by  = {1'b0, by_q};
  assign px  = {1'b0, px_q};
  assign sp  = {7'd0, spd_q};
  assign byh = by + BH;
  assign hit = byh <= PY && byh + sp >= PY && bx + BW > px && bx < px + PW;
  assign lvl_up = hit_q + 8'd1 == 8'(HITS_PER_LEVEL);
  always_comb begin
    st_d = st_q; bx_d = bx_q; by_d = by_q; px_d = px_q; spd_d = spd_q; sc_d = sc_q;
    hit_d = hit_q; srv_d = srv_q; lv_d = lv_q; dx_d = dx_q; dy_d = dy_q;
    if (endframe) begin
      if (st_q == SERVE || st_q == PLAY || st_q == MISS)
        px_d = (l && !r) ? (px < 11'd2 ? 10'd0 : px_q - 10'd2)
             : (r && !l) ? (px + 11'd2 > PMAX ? P_R : px_q + 10'd2) : px_q;
      case (st_q)
        IDLE: if (s) begin st_d = SERVE; srv_d = 8'(SERVE_FRAMES); end
        SERVE: begin
          bx_d = X0; by_d = Y0; dx_d = 1'b1; dy_d = 1'b1;
          srv_d = srv_q - 8'd1;
          if (srv_q == 8'd1) st_d = PLAY;
        end
        PLAY: begin
          if (dx_q) begin
            bx_d = bx + sp > XMAX ? X_R : bx_q + 10'(spd_q);
            dx_d = !(bx + sp > XMAX);
          end else begin
            bx_d = bx < sp ? 10'd0 : bx_q - 10'(spd_q);
            dx_d = bx < sp;
          end
          if (!dy_q) begin
            by_d = by < sp ? 10'd0 : by_q - 10'(spd_q);
            dy_d = by < sp;
          end else if (hit) begin
            by_d  = Y_HIT;
            dy_d  = 1'b0;
            sc_d  = &sc_q ? sc_q : sc_q + 8'd1;
            hit_d = lvl_up ? 8'd0 : hit_q + 8'd1;
            if (lvl_up && spd_q < 4'(SPEED_MAX)) spd_d = spd_q + 4'd1;
          end else if (by + sp >= YMAX) begin
            by_d = Y_MISS;
            st_d = MISS;
          end else by_d = by_q + 10'(spd_q);
        end
        MISS: begin
          lv_d  = lv_q - 2'd1;
          st_d  = lv_q == 2'd1 ? OVER : SERVE;
          srv_d = 8'(SERVE_FRAMES);
        end
        OVER: if (s) begin
          st_d = SERVE; sc_d = 8'd0; lv_d = 2'(LIVES_INIT); spd_d = 4'(SPEED_INIT);
          hit_d = 8'd0; srv_d = 8'(SERVE_FRAMES);
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge px_clk) begin
    if (reset) begin
      st_q <= IDLE; bx_q <= X0; by_q <= Y0; px_q <= P0; spd_q <= 4'(SPEED_INIT);
      sc_q <= 8'd0; hit_q <= 8'd0; srv_q <= 8'd0; lv_q <= 2'(LIVES_INIT);
      dx_q <= 1'b1; dy_q <= 1'b1; tick_q <= 1'b0;
      l_q <= 2'd0; r_q <= 2'd0; s_q <= 2'd0;
    end else begin
      st_q <= st_d; bx_q <= bx_d; by_q <= by_d; px_q <= px_d; spd_q <= spd_d;
      sc_q <= sc_d; hit_q <= hit_d; srv_q <= srv_d; lv_q <= lv_d;
      dx_q <= dx_d; dy_q <= dy_d; tick_q <= endframe;
      l_q <= {l_q[0], g.leftButton};
      r_q <= {r_q[0], g.rightButton};
      s_q <= {s_q[0], g.startButton};
    end
  end
  assign g.ball_x     = bx_q;
  assign g.ball_y     = by_q;
  assign g.paddle_x   = px_q;
  assign g.speed      = spd_q;
  assign g.score      = sc_q;
  assign g.lives      = lv_q;
  assign g.state      = st_q;
  assign g.frame_tick = tick_q;
endmodule

// File: tb/tb_pxs_fronton_ctrl.sv
// tb_pxs_fronton_ctrl: random play of the Fronton sequencer against a frame-level game model
module tb_pxs_fronton_ctrl;
  logic px_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 px_clk = ~px_clk;
  pxs_fronton_ctrl_if g();
  pxs_fronton_ctrl dut (.px_clk(px_clk), .reset(reset), .g(g));
  int errors = 0, checks = 0;
  int m_st, m_bx, m_by, m_px, m_spd, m_sc, m_lv, m_dx, m_dy, m_hits, m_srv, m_tick;
  bit bl, br, bs;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_st = 0; m_bx = 316; m_by = 100; m_px = 288; m_spd = 2; m_sc = 0; m_lv = 3;
    m_dx = 1; m_dy = 1; m_hits = 0; m_srv = 0;
  endfunction
  function automatic void model_frame(bit l, bit r, bit s);
    int opx = m_px, obx = m_bx, oby = m_by, nx, ny;
    if (m_st >= 1 && m_st <= 3) begin
      if (l && !r) m_px = (m_px - 2 < 0) ? 0 : m_px - 2;
      else if (r && !l) m_px = (m_px + 2 > 576) ? 576 : m_px + 2;
    end
    case (m_st)
      0: if (s) begin m_st = 1; m_srv = 60; end
      1: begin
        m_bx = 316; m_by = 100; m_dx = 1; m_dy = 1;
        m_srv--;
        if (m_srv == 0) m_st = 2;
      end
      2: begin
        nx = obx + m_dx * m_spd;
        if (nx > 632) begin m_bx = 632; m_dx = -1; end
        else if (nx < 0) begin m_bx = 0; m_dx = 1; end
        else m_bx = nx;
        if (m_dy < 0) begin
          ny = oby - m_spd;
          if (ny < 0) begin m_by = 0; m_dy = 1; end
          else m_by = ny;
        end else if (oby + 10 <= 440 && oby + 10 + m_spd >= 440 && obx + 8 > opx && obx < opx + 64) begin
          m_by = 430; m_dy = -1;
          m_sc = (m_sc == 255) ? 255 : m_sc + 1;
          m_hits++;
          if (m_hits == 4) begin
            m_hits = 0;
            if (m_spd < 8) m_spd++;
          end
        end else if (oby + m_spd >= 470) begin
          m_by = 470; m_st = 3;
        end else m_by = oby + m_spd;
      end
      3: begin
        m_lv--;
        if (m_lv == 0) m_st = 4;
        else begin m_st = 1; m_srv = 60; end
      end
      4: if (s) begin
        m_st = 1; m_sc = 0; m_lv = 3; m_spd = 2; m_hits = 0; m_srv = 60;
      end
      default: ;
    endcase
  endfunction
  task automatic check_all();
    check("state", g.state, m_st);
    check("ball_x", g.ball_x, m_bx);
    check("ball_y", g.ball_y, m_by);
    check("paddle_x", g.paddle_x, m_px);
    check("speed", g.speed, m_spd);
    check("score", g.score, m_sc);
    check("lives", g.lives, m_lv);
    check("frame_tick", g.frame_tick, m_tick);
  endtask
  task automatic cyc(bit e);
    g.VGAStr_i = e ? {3'($urandom), 10'd639, 10'd479}
                   : {3'($urandom), 10'($urandom_range(0, 639)), 10'($urandom_range(0, 478))};
    @(posedge px_clk);
    if (reset) model_reset();
    else if (e) model_frame(bl, br, bs);
    m_tick = (e && !reset) ? 1 : 0;
    #1;
    check_all();
  endtask
  task automatic frame(bit l, bit r, bit s);
    g.leftButton = l; g.rightButton = r; g.startButton = s;
    bl = l; br = r; bs = s;
    repeat (4) cyc(1'b0);
    cyc(1'b1);
  endtask
  initial begin
    int dir = 3, c;
    bit l, r, s;
    g.leftButton = 0; g.rightButton = 0; g.startButton = 0;
    g.VGAStr_i = '0;
    bl = 0; br = 0; bs = 0;
    model_reset();
    m_tick = 0;
    cyc(1'b0);
    cyc(1'b1);
    reset = 1'b0;
    check("rst_state", g.state, 0);
    check("rst_ball_x", g.ball_x, 316);
    check("rst_paddle_x", g.paddle_x, 288);
    frame(0, 0, 0);
    frame(0, 0, 0);
    check("idle_state", g.state, 0);
    check("idle_ball_y", g.ball_y, 100);
    frame(0, 0, 1);
    check("serve_entry", g.state, 1);
    repeat (60) frame(0, 0, 0);
    check("serve_done", g.state, 2);
    frame(0, 0, 0);
    check("play1_ball_x", g.ball_x, 318);
    check("play1_ball_y", g.ball_y, 102);
    for (int f = 0; f < 4000; f++) begin
      if (f == 1700) begin
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        check("midrst_state", g.state, 0);
      end
      if ((f / 200) % 3 == 0) begin
        if ($urandom_range(0, 19) == 0) dir = $urandom_range(0, 3);
        l = (dir == 0 || dir == 2);
        r = (dir == 1 || dir == 2);
      end else begin
        c = m_bx + 4 - (m_px + 32);
        l = c < -4;
        r = c > 4;
        if ($urandom_range(0, 15) == 0) begin l = 1; r = 1; end
      end
      s = $urandom_range(0, 7) == 0;
      frame(l, r, s);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
